// File: rtl/floattoint_arbiter.sv
// Round-robin front end that time-shares one float-to-int16 converter among NREQ
// requesters, sequencing the converter's reset/start, done wait and tagged response.
module floattoint_arbiter #(
  parameter int NREQ         = 4,
  parameter int START_CYCLES = 1,
  parameter int TIMEOUT      = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [32*NREQ-1:0]      req_float_i,
  output logic [NREQ-1:0]         req_ack_o,
  output logic                    resp_valid_o,
  output logic [$clog2(NREQ)-1:0] resp_id_o,
  output logic [15:0]             resp_int_o,
  output logic                    resp_err_o,
  output logic                    busy_o,
  output logic                    conv_reset_o,
  output logic [31:0]             conv_floatin_o,
  input  logic [15:0]             conv_intout_i,
  input  logic                    conv_done_i
);
  localparam int ID_W = $clog2(NREQ);
  localparam int CMAX = (START_CYCLES > TIMEOUT) ? START_CYCLES : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0] rr_q, rr_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            vld_q, vld_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [15:0]     int_q, int_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            crst_q, crst_d;
  logic [31:0]     fin_q, fin_d;

  logic [NREQ-1:0][31:0] flt;
  logic [NREQ-1:0]       rot;
  logic                  found;
  logic [ID_W-1:0]       off, win;
  logic [ID_W:0]         sum, nxt;

  assign flt = req_float_i;

  // Rotate so bit 0 is the rr pointer; the lowest set bit is then the winner's offset.
  assign rot = (req_valid_i >> rr_q) | (req_valid_i << (NREQ - int'(rr_q)));

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = ID_W'(k);
      end
    end
  end

  assign sum = {1'b0, rr_q} + {1'b0, off};
  assign win = ID_W'((sum >= (ID_W+1)'(NREQ)) ? sum - (ID_W+1)'(NREQ) : sum);
  assign nxt = {1'b0, win} + (ID_W+1)'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    ack_d   = '0;
    vld_d   = 1'b0;
    id_d    = id_q;
    int_d   = int_q;
    err_d   = err_q;
    crst_d  = crst_q;
    fin_d   = fin_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          ack_d[win] = 1'b1;
          fin_d      = flt[win];
          crst_d     = 1'b1;
          id_d       = win;
          rr_d       = (nxt == (ID_W+1)'(NREQ)) ? '0 : ID_W'(nxt);
          cnt_d      = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (cnt_q == CW'(START_CYCLES - 1)) begin
          crst_d  = 1'b0;
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // Done is deliberately not looked at here: it may still be left over from the last job.
      S_SETTLE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (conv_done_i) begin
          int_d   = conv_intout_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          int_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        vld_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      ack_q   <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
      int_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      crst_q  <= 1'b0;
      fin_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      ack_q   <= ack_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      int_q   <= int_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      crst_q  <= crst_d;
      fin_q   <= fin_d;
    end
  end

  assign req_ack_o      = ack_q;
  assign resp_valid_o   = vld_q;
  assign resp_id_o      = id_q;
  assign resp_int_o     = int_q;
  assign resp_err_o     = err_q;
  assign busy_o         = busy_q;
  assign conv_reset_o   = crst_q;
  assign conv_floatin_o = fin_q;
endmodule
